// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, the fetch queue entry type and the default reset PC.
// Imported by fetch_queue and instruction_fetch_unit.
package fetch_pkg;
    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetch_entry_t with flush.
// Ports: clk, rst_n (async active-low); i_push/i_pop/i_flush controls and i_data
// write entry; o_head is the registered head entry, o_count/o_full/o_empty occupancy.
// Flush beats push; a pop alongside a flush is legal and simply absorbed.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_data,
    output fetch_entry_t o_head,
    output logic [AW:0]  o_count,
    output logic         o_full,
    output logic         o_empty
);
    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd];
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & ~i_flush & (~o_full | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem   <= '{default: '0};
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_pop)
                r_rd <= r_rd + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC owner and fetch front end feeding decode.
// Ports: clk, rst_n (async active-low); i_fetch_en gates fetching;
// o_imem_addr/i_imem_instr combinational instruction memory port;
// i_redirect_valid/i_redirect_pc restart fetch; o_out_valid/i_out_ready/
// o_out_instr/o_out_pc hand queued instructions to decode.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int              QUEUE_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_fetch_en,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic [31:0]     i_imem_instr,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [31:0]     o_out_instr,
    output logic [XLEN-1:0] o_out_pc
);
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    logic [XLEN-1:0] r_fetch_pc;
    logic [CW-1:0]   w_count;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_push;
    fetch_entry_t    w_head;

    assign w_pop  = o_out_valid & i_out_ready;
    // A slot freed by this cycle's pop can be refilled in the same cycle.
    assign w_push = i_fetch_en & ~i_redirect_valid & ((w_count < CW'(QUEUE_DEPTH)) | w_pop);

    assign o_imem_addr = r_fetch_pc;
    assign o_out_valid = ~w_empty;
    assign o_out_instr = w_head.instr;
    assign o_out_pc    = w_head.pc;

    always_comb assert (w_full == (w_count == CW'(QUEUE_DEPTH)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_fetch_pc <= RESET_PC;
        else if (i_redirect_valid)
            r_fetch_pc <= i_redirect_pc & ~XLEN'(INSTR_BYTES - 1);
        else if (w_push)
            r_fetch_pc <= r_fetch_pc + XLEN'(INSTR_BYTES);
    end

    fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (i_redirect_valid),
        .i_data  ('{pc: r_fetch_pc, instr: i_imem_instr}),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed scenarios plus random traffic against a queue-based model.
module tb_instruction_fetch_unit;
    logic        clk = 0, rst_n = 0, fetch_en = 0, redirect_valid = 0, out_ready = 0;
    logic [31:0] redirect_pc = 0;
    logic [31:0] imem_addr, imem_instr, out_instr, out_pc;
    logic        out_valid;
    int          errors = 0, checks = 0;
    logic [31:0] mq[$];
    logic [31:0] mpc = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_at(input logic [31:0] a);
        if (a == 32'h0) return 32'h00500093;
        if (a == 32'h4) return 32'h00a00113;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    assign imem_instr = instr_at(imem_addr);

    instruction_fetch_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_fetch_en       (fetch_en),
        .o_imem_addr      (imem_addr),
        .i_imem_instr     (imem_instr),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .o_out_valid      (out_valid),
        .i_out_ready      (out_ready),
        .o_out_instr      (out_instr),
        .o_out_pc         (out_pc)
    );

    // Apply inputs for the next rising edge and advance the model by that edge.
    task automatic drive(input bit fe, input bit rdy, input bit rv, input logic [31:0] rpc);
        fetch_en = fe; out_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
        if (rdy && mq.size() != 0) void'(mq.pop_front());
        if (rv) begin
            mq.delete();
            mpc = {rpc[31:2], 2'b00};
        end else if (fe && mq.size() < 2) begin
            mq.push_back(mpc);
            mpc = mpc + 32'd4;
        end
    endtask

    task automatic do_reset();
        rst_n = 0; fetch_en = 0; out_ready = 0; redirect_valid = 0; redirect_pc = 0;
        mq.delete(); mpc = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want %h", imem_addr, 32'h0); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", out_pc); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", out_instr); end
        rst_n = 1;
    endtask

    task automatic test_basic();
        drive(1, 1, 0, 0); @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("FAIL basic_pc0: got v=%b pc=%h want v=1 pc=0", out_valid, out_pc); end
        checks++; if (out_instr !== 32'h00500093) begin errors++; $display("FAIL basic_instr0: got %h want 00500093", out_instr); end
        drive(1, 1, 0, 0); @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h4) begin errors++; $display("FAIL basic_pc1: got v=%b pc=%h want v=1 pc=4", out_valid, out_pc); end
        checks++; if (out_instr !== 32'h00a00113) begin errors++; $display("FAIL basic_instr1: got %h want 00a00113", out_instr); end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 0, 0); @(negedge clk);
            checks++; if (imem_addr !== ((k == 0) ? 32'h4 : 32'h8)) begin errors++; $display("FAIL bp_addr%0d: got %h want %h", k, imem_addr, (k == 0) ? 32'h4 : 32'h8); end
        end
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_valid !== 1'b1 || out_pc !== 32'(i * 4)) begin errors++; $display("FAIL bp_order%0d: got v=%b pc=%h want v=1 pc=%h", i, out_valid, out_pc, 32'(i * 4)); end
            drive(1, 1, 0, 0); @(negedge clk);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        drive(1, 0, 0, 0); @(negedge clk);
        drive(1, 0, 0, 0); @(negedge clk);
        drive(1, 1, 0, 0); @(negedge clk);
        checks++; if (out_pc !== 32'h4) begin errors++; $display("FAIL redir_head: got %h want 4", out_pc); end
        drive(1, 0, 1, 32'h13); @(negedge clk);
        checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h10) begin errors++; $display("FAIL redir_flush: got v=%b addr=%h want v=0 addr=10", out_valid, imem_addr); end
        drive(1, 1, 0, 0); @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h10 || out_instr !== instr_at(32'h10)) begin errors++; $display("FAIL redir_out: got v=%b pc=%h i=%h want v=1 pc=10 i=%h", out_valid, out_pc, out_instr, instr_at(32'h10)); end
        do_reset();
        drive(1, 0, 0, 0); @(negedge clk);
        drive(1, 0, 0, 0); @(negedge clk);
        checks++; if (out_pc !== 32'h0 || out_valid !== 1'b1) begin errors++; $display("FAIL rpop_head: got v=%b pc=%h want v=1 pc=0", out_valid, out_pc); end
        drive(1, 1, 1, 32'h40); @(negedge clk);
        checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h40) begin errors++; $display("FAIL rpop_flush: got v=%b addr=%h want v=0 addr=40", out_valid, imem_addr); end
        drive(1, 1, 0, 0); @(negedge clk);
        checks++; if (out_pc !== 32'h40 || out_valid !== 1'b1) begin errors++; $display("FAIL rpop_next0: got v=%b pc=%h want v=1 pc=40", out_valid, out_pc); end
        drive(1, 1, 0, 0); @(negedge clk);
        checks++; if (out_pc !== 32'h44) begin errors++; $display("FAIL rpop_next1: got %h want 44", out_pc); end
    endtask

    task automatic test_wrap_and_b2b();
        drive(1, 1, 1, 32'hFFFF_FFFC); @(negedge clk);
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr: got %h want fffffffc", imem_addr); end
        drive(1, 1, 0, 0); @(negedge clk);
        checks++; if (out_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_pc0: got pc=%h addr=%h want pc=fffffffc addr=0", out_pc, imem_addr); end
        drive(1, 1, 0, 0); @(negedge clk);
        checks++; if (out_pc !== 32'h0 || out_valid !== 1'b1) begin errors++; $display("FAIL wrap_pc1: got v=%b pc=%h want v=1 pc=0", out_valid, out_pc); end
        drive(1, 1, 1, 32'h100); @(negedge clk);
        drive(1, 1, 1, 32'h203); @(negedge clk);
        checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h200) begin errors++; $display("FAIL b2b_addr: got v=%b addr=%h want v=0 addr=200", out_valid, imem_addr); end
        drive(1, 1, 0, 0); @(negedge clk);
        checks++; if (out_pc !== 32'h200) begin errors++; $display("FAIL b2b_pc: got %h want 200", out_pc); end
    endtask

    task automatic test_fetch_disable();
        do_reset();
        drive(1, 0, 0, 0); @(negedge clk);
        drive(1, 0, 0, 0); @(negedge clk);
        drive(0, 1, 0, 0); @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h4 || imem_addr !== 32'h8) begin errors++; $display("FAIL dis_drain: got v=%b pc=%h addr=%h want v=1 pc=4 addr=8", out_valid, out_pc, imem_addr); end
        for (int k = 0; k < 2; k++) begin
            drive(0, 1, 0, 0); @(negedge clk);
            checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h8) begin errors++; $display("FAIL dis_idle%0d: got v=%b addr=%h want v=0 addr=8", k, out_valid, imem_addr); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 0); @(negedge clk);
        end
        checks++; if (out_valid !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL ar_full: got v=%b addr=%h want v=1 addr=8", out_valid, imem_addr); end
        #2 rst_n = 0;
        #1;
        checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL ar_async: got v=%b addr=%h want v=0 addr=0", out_valid, imem_addr); end
        checks++; if (out_pc !== 32'h0 || out_instr !== 32'h0) begin errors++; $display("FAIL ar_outs: got pc=%h i=%h want 0 0", out_pc, out_instr); end
        mq.delete(); mpc = 0;
        @(negedge clk);
        rst_n = 1;
        drive(1, 1, 0, 0); @(negedge clk);
        checks++; if (out_pc !== 32'h0 || out_instr !== 32'h00500093 || out_valid !== 1'b1) begin errors++; $display("FAIL ar_restart: got v=%b pc=%h i=%h want v=1 pc=0 i=00500093", out_valid, out_pc, out_instr); end
    endtask

    task automatic test_random();
        logic [31:0] rpc;
        for (int n = 0; n < 400; n++) begin
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom());
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 11) == 0, rpc);
            @(negedge clk);
            checks++; if (imem_addr !== mpc) begin errors++; $display("FAIL rnd_addr@%0d: got %h want %h", n, imem_addr, mpc); end
            checks++; if (out_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_valid@%0d: got %b want %b", n, out_valid, mq.size() != 0); end
            if (mq.size() != 0) begin
                checks++; if (out_pc !== mq[0] || out_instr !== instr_at(mq[0])) begin errors++; $display("FAIL rnd_head@%0d: got pc=%h i=%h want pc=%h i=%h", n, out_pc, out_instr, mq[0], instr_at(mq[0])); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect();
        test_wrap_and_b2b();
        test_fetch_disable();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Front-end reader for the RV32I instruction memory. Owns the program counter, presents word-aligned byte addresses to the combinational instruction memory, captures the returned instruction words with their PCs into a small queue, and hands them to decode over a valid/ready handshake. Branch and jump redirects from execute flush the queue and restart fetch at the new PC.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
- QUEUE_DEPTH, 2, entries in the fetch queue (power of two, ≥2)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- fetch_en  in  1  permit fetching; 0 freezes the PC, while the queue still drains
- imem_addr  out  32  byte address to instruction memory (= fetch_pc)
- imem_instr  in  32  instruction word returned combinationally for imem_addr
- redirect_valid  in  1  one-cycle redirect request
- redirect_pc  in  32  new PC; bits [1:0] ignored (treated as 0)
- out_valid  out  1  queue head holds a valid instruction
- out_ready  in  1  decode accepts head this cycle
- out_instr  out  32  head instruction word
- out_pc  out  32  byte address of head instruction

## Operation
- State: fetch_pc (32b), queue of {pc, instr} entries, count (0..QUEUE_DEPTH).
- imem_addr = fetch_pc, combinational from the register; memory returns the word the same cycle.
- pop = out_valid & out_ready.
- push = fetch_en & ~redirect_valid & (count < QUEUE_DEPTH | pop).
- On push: enqueue {fetch_pc, imem_instr}; fetch_pc <= fetch_pc + 4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Full queue with no pop: no push, fetch_pc holds, imem_addr is stable.
- Redirect has priority over push:
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - All queue entries are flushed and count <= 0.
  - A head transfer (pop) in the same cycle still completes, because decode has already sampled it.
  - Nothing is pushed that cycle.
- fetch_en = 0: no push and the PC holds; pops continue normally.
- out_valid = (count != 0). out_instr and out_pc come from the head entry, registered, with no combinational path from imem_instr.
- Queue order is strictly FIFO; PCs leave the block in fetch order, each +4 from the previous, except across a redirect.

## Timing
- Reset (async assert, sync-released at clk edge):
  - fetch_pc = RESET_PC, so imem_addr = RESET_PC.
  - count = 0 and out_valid = 0.
  - out_instr = 32'h0 and out_pc = 32'h0.
- Fetch-to-output latency: 1 cycle. A word presented at imem_addr in cycle N with push appears on out_* in cycle N+1 if the queue was empty.
- Throughput: 1 instruction/cycle sustained while out_ready = 1 and fetch_en = 1.
- Redirect latency:
  - Redirect asserted in cycle N puts redirect_pc on imem_addr in cycle N+1.
  - Its instruction reaches out_* in cycle N+2.
  - out_valid = 0 in cycle N+1.
- Back-to-back redirects: the last one wins; each flushes.
- Reset mid-operation: immediate return to the reset values; queued entries are lost.
- Decode must hold out_ready independent of out_valid. out_* stays stable while out_valid & ~out_ready.

## Structure
- Package fetch_pkg holds:
  - XLEN = 32.
  - INSTR_BYTES = 4.
  - typedef fetch_entry_t {pc[XLEN-1:0], instr[31:0]}.
  - The default RESET_PC constant.
- Sub-module fetch_queue: parameterised synchronous FIFO of fetch_entry_t.
  - Inputs: push, pop, flush.
  - Outputs: count and full/empty.
  - flush takes priority over push; flush with a simultaneous pop is legal.
- Top level holds the PC register, push/redirect logic and output wiring.

## Test plan
- Reset, memory preloaded with 32'h00500093 and 32'h00a00113 at word 0 and word 1, out_ready = 1, fetch_en = 1:
  - Cycle 1: out_pc = 0, out_instr = 32'h00500093.
  - Cycle 2: out_pc = 4, out_instr = 32'h00a00113.
- Backpressure, out_ready = 0 for 5 cycles:
  - count saturates at 2 and imem_addr freezes at 8.
  - On release, PCs 0, 4, 8 emerge in order with none lost or duplicated.
- Redirect to 32'h0000_0013 while the queue holds PCs 4 and 8:
  - The queue flushes; the next imem_addr is 32'h10.
  - The next out_pc is 32'h10, two cycles after the redirect.
  - Redirect plus pop in the same cycle: the popped head is counted once and the rest are dropped.
- PC wrap:
  - Redirect to 32'hFFFF_FFFC, then fetch two instructions.
  - Expected out_pc sequence: FFFF_FFFC, 0000_0000.
- fetch_en = 0 with 2 entries queued and out_ready = 1:
  - Both entries drain, then out_valid = 0 and imem_addr is unchanged.
- Assert rst_n mid-stream with the queue full:
  - out_valid goes to 0 without waiting for a clk edge; imem_addr = RESET_PC.
  - Fetch restarts at RESET_PC after release.
